// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - phase-offset and saturating-add helpers shared by pwm_multiphase
package pwm_pkg;

  function automatic int unsigned phase_offset(input int unsigned channel,
                                               input int unsigned period,
                                               input int unsigned channels);
    return (channel * period) / channels;
  endfunction

  // Edge times clamp at the period so an overlong setting simply never fires.
  function automatic int unsigned sat_add(input int unsigned a,
                                          input int unsigned b,
                                          input int unsigned limit);
    int unsigned sum;
    sum = a + b;
    return (sum > limit) ? limit : sum;
  endfunction

endpackage

// File: rtl/pwm_channel_decode.sv
// rtl/pwm_channel_decode.sv - one half-bridge: window decode, interlock and registered gate outputs
module pwm_channel_decode
  import pwm_pkg::*;
#(
  parameter int bitwidth = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [bitwidth-1:0] local_count,
  input  logic [bitwidth-1:0] t1,
  input  logic [bitwidth-1:0] t2,
  input  logic [bitwidth-1:0] t3,
  input  logic [bitwidth-1:0] t4,
  input  logic                force_off,
  output logic                highside,
  output logic                lowside,
  output logic                both_off
);

  logic hs_raw;
  logic ls_raw;
  logic hs_next;
  logic ls_next;

  always_comb begin
    hs_raw  = (local_count >= t1) && (local_count < t2);
    ls_raw  = (local_count >= t3) && (local_count < t4);
    // Interlock: a simultaneous decode turns both gates off rather than shooting through.
    hs_next = !force_off && hs_raw && !ls_raw;
    ls_next = !force_off && ls_raw && !hs_raw;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      highside <= 1'b0;
      lowside  <= 1'b0;
      both_off <= 1'b1;
    end else begin
      highside <= hs_next;
      lowside  <= ls_next;
      both_off <= !hs_next && !ls_next;
    end
  end

endmodule

// File: rtl/pwm_multiphase.sv
// rtl/pwm_multiphase.sv - interleaved N-channel half-bridge PWM with shadowed settings and fault blanking
// Optional PWM_FAULT_LATCH_EN: sticky fault flag cleared by fault_clear, reported on fault_active.
module pwm_multiphase
  import pwm_pkg::*;
#(
  parameter int channels          = 3,
  parameter int tick_count_period = 100,
  parameter int bitwidth          = $clog2(tick_count_period) + 1,
  parameter int deadtime_reset    = 12
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [channels*bitwidth-1:0] tick_count_highside,
  input  logic [channels*bitwidth-1:0] tick_count_lowside,
  input  logic [bitwidth-1:0]          deadtime_hs_to_ls,
  input  logic [bitwidth-1:0]          deadtime_ls_to_hs,
  input  logic                         update_request,
  output logic                         update_ack,
  input  logic                         fault,
`ifdef PWM_FAULT_LATCH_EN
  input  logic                         fault_clear,
  output logic                         fault_active,
`endif
  output logic [bitwidth-1:0]          tick_counter,
  output logic                         period_start,
  output logic [channels-1:0]          highside_output,
  output logic [channels-1:0]          lowside_output,
  output logic [channels-1:0]          both_gates_off_output
);

  localparam logic [bitwidth-1:0] last_tick = bitwidth'(tick_count_period - 1);
  localparam logic [bitwidth-1:0] dt_reset  = bitwidth'(deadtime_reset);

  logic [channels*bitwidth-1:0] pend_hs, pend_ls, act_hs, act_ls;
  logic [bitwidth-1:0]          pend_dt_hl, pend_dt_lh, act_dt_hl, act_dt_lh;
  logic                         pending;
  logic                         copy;
  logic                         fault_src;
  logic                         fault_hold;
  logic                         force_off;

  assign period_start = (tick_counter == '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                         tick_counter <= '0;
    else if (!enable)                   tick_counter <= '0;
    else if (tick_counter == last_tick) tick_counter <= '0;
    else                                tick_counter <= tick_counter + 1'b1;
  end

  // Shadow set moves to active only at the period boundary, or at once while idle.
  assign copy = pending && (!enable || (tick_counter == last_tick));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pending    <= 1'b0;
      pend_hs    <= '0;
      pend_ls    <= '0;
      pend_dt_hl <= dt_reset;
      pend_dt_lh <= dt_reset;
      act_hs     <= '0;
      act_ls     <= '0;
      act_dt_hl  <= dt_reset;
      act_dt_lh  <= dt_reset;
      update_ack <= 1'b0;
    end else begin
      update_ack <= copy;
      if (copy) begin
        act_hs    <= pend_hs;
        act_ls    <= pend_ls;
        act_dt_hl <= pend_dt_hl;
        act_dt_lh <= pend_dt_lh;
      end
      if (update_request) begin
        pending    <= 1'b1;
        pend_hs    <= tick_count_highside;
        pend_ls    <= tick_count_lowside;
        pend_dt_hl <= deadtime_hs_to_ls;
        pend_dt_lh <= deadtime_ls_to_hs;
      end else if (copy) begin
        pending <= 1'b0;
      end
    end
  end

`ifdef PWM_FAULT_LATCH_EN
  logic fault_latched;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)           fault_latched <= 1'b0;
    else if (fault)       fault_latched <= 1'b1;
    else if (fault_clear) fault_latched <= 1'b0;
  end

  assign fault_src    = fault || fault_latched;
  assign fault_active = fault_latched;
`else
  assign fault_src = fault;
`endif

  // After a fault the gates wait for a clean period boundary before resuming.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)            fault_hold <= 1'b0;
    else if (fault_src)    fault_hold <= 1'b1;
    else if (period_start) fault_hold <= 1'b0;
  end

  assign force_off = !enable || fault_src || (fault_hold && !period_start);

  for (genvar c = 0; c < channels; c++) begin : g_ch
    localparam int unsigned offset = phase_offset(c, tick_count_period, channels);

    logic [bitwidth:0]   local_sum;
    logic [bitwidth-1:0] local_count;
    logic [bitwidth-1:0] t1, t2, t3, t4;
    int unsigned         e1, e2, e3, e4;

    always_comb begin
      local_sum = {1'b0, tick_counter} + (bitwidth + 1)'(offset);
      if (local_sum >= (bitwidth + 1)'(tick_count_period))
        local_sum = local_sum - (bitwidth + 1)'(tick_count_period);
      local_count = local_sum[bitwidth-1:0];
    end

    always_comb begin
      e1 = sat_add(32'(act_dt_lh), 32'd0, tick_count_period);
      e2 = sat_add(e1, 32'(act_hs[c*bitwidth +: bitwidth]), tick_count_period);
      e3 = sat_add(e2, 32'(act_dt_hl), tick_count_period);
      e4 = sat_add(e3, 32'(act_ls[c*bitwidth +: bitwidth]), tick_count_period);
      t1 = bitwidth'(e1);
      t2 = bitwidth'(e2);
      t3 = bitwidth'(e3);
      t4 = bitwidth'(e4);
    end

    pwm_channel_decode #(.bitwidth(bitwidth)) u_decode (
      .clock       (clock),
      .reset       (reset),
      .local_count (local_count),
      .t1          (t1),
      .t2          (t2),
      .t3          (t3),
      .t4          (t4),
      .force_off   (force_off),
      .highside    (highside_output[c]),
      .lowside     (lowside_output[c]),
      .both_off    (both_gates_off_output[c])
    );
  end

endmodule

// File: doc/pwm_multiphase.md
Name: pwm_multiphase

Overview:
- N-channel half-bridge PWM generator with an internal period counter and a fixed phase offset per channel (interleaved multiphase converters).
- Per channel: highside/lowside on-times, runtime dead times, and DCM third interval (both gates off).
- New settings go into shadow registers and become active only at the period boundary, so no period ever mixes old and new values.
- Sits between the control loop (which writes tick counts) and the gate driver pins.

Parameters:
- channels, 3, number of half bridges.
- tick_count_period, 100, PWM period in clock ticks.
- bitwidth, $clog2(tick_count_period)+1, width of all tick quantities.
- deadtime_reset, 12, dead-time value loaded at reset for both transitions.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous active-low reset.
- enable  in  1  run (1) or hold (0).
- tick_count_highside  in  channels*bitwidth  packed highside on-times; channel c occupies bits [c*bitwidth +: bitwidth].
- tick_count_lowside  in  channels*bitwidth  packed lowside on-times, same packing.
- deadtime_hs_to_ls  in  bitwidth  dead time after highside falls.
- deadtime_ls_to_hs  in  bitwidth  dead time before highside rises.
- update_request  in  1  one-cycle strobe; captures all tick and dead-time inputs into the pending set.
- update_ack  out  1  one-cycle pulse when the pending set becomes active.
- fault  in  1  force all gates off.
- tick_counter  out  bitwidth  master counter.
- period_start  out  1  pulse while tick_counter==0.
- highside_output  out  channels  gate signals.
- lowside_output  out  channels  gate signals.
- both_gates_off_output  out  channels  high when both gates of a channel are low.

Behaviour:
- Reset values:
  - counter = 0; all gate outputs 0; both_gates_off_output all 1.
  - update_ack = 0; pending flag = 0.
  - Active set: hs = ls = 0, both dead times = deadtime_reset.
- Counter:
  - Counts 0..tick_count_period-1 and wraps to 0.
  - enable=0 holds the counter at 0 and forces all gates low.
  - On enable 0->1, counting starts from 0 on the next edge.
- Local count per channel:
  - local_c = tick_counter + off_c, where off_c = c*tick_count_period/channels (integer division).
  - Subtract tick_count_period once if local_c >= tick_count_period.
- Edge times, computed from the active set at bitwidth+1 bits:
  - t1 = dt_ls_hs
  - t2 = t1 + hs
  - t3 = t2 + dt_hs_ls
  - t4 = t3 + ls
  - Each t is saturated at tick_count_period.
- Gate decode:
  - highside = (t1 <= local < t2).
  - lowside = (t3 <= local < t4).
  - An on-time of 0, or t1 >= period, gives a gate that never rises.
  - Highside and lowside are never high together, by construction plus an output interlock: if both decode high, both are driven low.
- Latency: gate outputs are registered, 1 cycle after the tick_counter value that produced them.
- Update handshake:
  - update_request captures the inputs into the pending set and sets the pending flag.
  - A further request while pending overwrites the pending values.
  - At tick_counter==tick_count_period-1 with pending set: pending copies to active, the flag clears, and update_ack pulses in the cycle tick_counter==0.
  - If update_request coincides with the copy cycle, the new values are captured into pending and stay pending for the next period.
  - With enable=0, pending copies to active immediately on the next edge.
- Fault:
  - fault=1 drives all gate outputs 0 on the next edge.
  - The counter keeps running.
  - Gates resume at the first period_start after fault deasserts.
- Reset mid-period: all outputs go to their reset values immediately (asynchronously); pending updates are discarded.

Optional Feature:
- Macro: PWM_FAULT_LATCH_EN.
- With the macro: fault sets a sticky fault_latched flag.
  - Gates stay off until the new input fault_clear is pulsed while fault=0.
  - Output fault_active reports the flag.
  - Gates resume at the next period_start.
- Without the macro: no sticky flag; the ports fault_clear and fault_active are absent.

Decomposition:
- Shared package pwm_pkg: the phase-offset function and the saturating-add function.
- One natural sub-module, pwm_channel_decode, instantiated once per channel. It takes local count, edge times and fault, and returns the registered hs/ls/both_off outputs with the interlock.

Test Plan (period=100, channels=3, dt=12 unless stated):
- Update to hs=30, ls=30; apply update_request mid-period:
  - update_ack pulses at the next tick 0.
  - ch0 highside high for local 12..41; lowside high for local 54..83.
  - ch1 waveforms shifted by 33 ticks, ch2 by 66 ticks.
  - Outputs lag the counter by 1 cycle.
- hs=80, ls=50: t2=92, t3=100 saturates → lowside never rises, both_gates_off_output=1 from local 92 to 11.
- Two update_requests in one period (hs=10 then hs=20): only hs=20 becomes active; update_ack pulses once.
- fault asserted at tick 40 and deasserted at tick 60:
  - All gates go low at 41.
  - Gates stay low until the next tick 0, then resume.
  - With PWM_FAULT_LATCH_EN, gates stay off until fault_clear.
- reset asserted mid-highside: outputs go to 0 immediately; after release, the active set is hs=ls=0 and no gate rises.
- enable=0 with update_request: activation is immediate and the counter is held at 0; after enable=1, the first period uses the new values.
